// File: rtl/macload_csr_bank_pkg.sv
// Shared CSR constants for the MAC-load register bank: op codes, address map,
// register indices and the A/W group membership used for counter resets.
package macload_csr_bank_pkg;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] CSR_A_ADDR       = 12'h7C0;
    localparam logic [11:0] CSR_W_ADDR       = 12'h7C1;
    localparam logic [11:0] CSR_A_STRIDE     = 12'h7C2;
    localparam logic [11:0] CSR_W_STRIDE     = 12'h7C3;
    localparam logic [11:0] CSR_A_ROLLBACK   = 12'h7C4;
    localparam logic [11:0] CSR_W_ROLLBACK   = 12'h7C5;
    localparam logic [11:0] CSR_A_SKIP       = 12'h7C6;
    localparam logic [11:0] CSR_W_SKIP       = 12'h7C7;
    localparam logic [11:0] CSR_MACLOAD_CTRL = 12'h7C8;

    localparam int NUM_REGS       = 9;
    localparam int IDX_A_ADDR     = 0;
    localparam int IDX_W_ADDR     = 1;
    localparam int IDX_A_STRIDE   = 2;
    localparam int IDX_W_STRIDE   = 3;
    localparam int IDX_A_ROLLBACK = 4;
    localparam int IDX_W_ROLLBACK = 5;
    localparam int IDX_A_SKIP     = 6;
    localparam int IDX_W_SKIP     = 7;
    localparam int IDX_CTRL       = 8;

    // One bit per register index; CTRL belongs to neither group.
    localparam logic [NUM_REGS-1:0] A_GROUP_MASK = 9'b0_0101_0101;
    localparam logic [NUM_REGS-1:0] W_GROUP_MASK = 9'b0_1010_1010;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0003;
    localparam logic [31:0] CTRL_MASK  = 32'h0000_0003;

    function automatic logic [11:0] reg_addr(input int idx);
        case (idx)
            IDX_A_ADDR:     return CSR_A_ADDR;
            IDX_W_ADDR:     return CSR_W_ADDR;
            IDX_A_STRIDE:   return CSR_A_STRIDE;
            IDX_W_STRIDE:   return CSR_W_STRIDE;
            IDX_A_ROLLBACK: return CSR_A_ROLLBACK;
            IDX_W_ROLLBACK: return CSR_W_ROLLBACK;
            IDX_A_SKIP:     return CSR_A_SKIP;
            IDX_W_SKIP:     return CSR_W_SKIP;
            IDX_CTRL:       return CSR_MACLOAD_CTRL;
            default:        return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/macload_csr_bank_if.sv
// Bus bundle between the CSR path / address controller (master) and the
// MAC-load register bank (slave).
interface macload_csr_bank_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        sw_op_i;
    logic [11:0]       sw_addr_i;
    logic [DATA_W-1:0] sw_wdata_i;
    logic              sw_hit_o;
    logic [DATA_W-1:0] sw_rdata_o;
    logic [1:0]        hw_op_i;
    logic [11:0]       hw_addr_i;
    logic [DATA_W-1:0] hw_wdata_i;
    logic [DATA_W-1:0] a_address_o;
    logic [DATA_W-1:0] w_address_o;
    logic [DATA_W-1:0] a_stride_o;
    logic [DATA_W-1:0] w_stride_o;
    logic [DATA_W-1:0] a_rollback_o;
    logic [DATA_W-1:0] w_rollback_o;
    logic [DATA_W-1:0] a_skip_o;
    logic [DATA_W-1:0] w_skip_o;
    logic              csr_a_rstn_o;
    logic              csr_w_rstn_o;
    logic              hw_drop_o;

    modport master (
        output sw_op_i, sw_addr_i, sw_wdata_i, hw_op_i, hw_addr_i, hw_wdata_i,
        input  sw_hit_o, sw_rdata_o, a_address_o, w_address_o, a_stride_o, w_stride_o,
               a_rollback_o, w_rollback_o, a_skip_o, w_skip_o,
               csr_a_rstn_o, csr_w_rstn_o, hw_drop_o
    );

    modport slave (
        input  sw_op_i, sw_addr_i, sw_wdata_i, hw_op_i, hw_addr_i, hw_wdata_i,
        output sw_hit_o, sw_rdata_o, a_address_o, w_address_o, a_stride_o, w_stride_o,
               a_rollback_o, w_rollback_o, a_skip_o, w_skip_o,
               csr_a_rstn_o, csr_w_rstn_o, hw_drop_o
    );
endinterface

// File: rtl/macload_csr_bank_reg.sv
// One bank register: software WRITE/SET/CLEAR decode plus an optional gated
// hardware write port where software always wins a same-cycle collision.
module macload_csr_reg
    import macload_csr_bank_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0] WR_MASK   = {DATA_W{1'b1}},
    parameter bit              HAS_HW    = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        sw_op_i,
    input  logic              sw_sel_i,
    input  logic [DATA_W-1:0] sw_wdata_i,
    input  logic              hw_we_i,
    input  logic              hw_en_i,
    input  logic [DATA_W-1:0] hw_wdata_i,
    output logic [DATA_W-1:0] q_o,
    output logic              sw_wrote_o,
    output logic              hw_dropped_o
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_sw_val;
    logic [DATA_W-1:0] w_q_next;
    logic              w_sw_act;
    logic              w_hw_take;

    assign w_sw_act = sw_sel_i && (sw_op_i != CSR_OP_NONE);

    always_comb begin
        w_sw_val = r_q;
        case (sw_op_i)
            CSR_OP_WRITE: w_sw_val = sw_wdata_i;
            CSR_OP_SET:   w_sw_val = r_q | sw_wdata_i;
            CSR_OP_CLEAR: w_sw_val = r_q & ~sw_wdata_i;
            default:      w_sw_val = r_q;
        endcase
    end

    assign w_hw_take    = HAS_HW && hw_we_i && hw_en_i && !w_sw_act;
    assign hw_dropped_o = HAS_HW && hw_we_i && !w_hw_take;
    assign sw_wrote_o   = w_sw_act;

    // Bits outside WR_MASK never leave their reset value.
    assign w_q_next = w_sw_act  ? (w_sw_val & WR_MASK) :
                      w_hw_take ? hw_wdata_i : r_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/macload_csr_bank.sv
// MAC-load address-generation CSR bank: nine registers, software/hardware
// write arbitration, and registered counter-reset / drop strobes.
module macload_csr_bank
    import macload_csr_bank_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    macload_csr_bank_if.slave bus
);

    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_sw_wrote;
    logic [NUM_REGS-1:0] w_hw_dropped;
    logic                w_hw_write;
    logic                r_a_rstn;
    logic                r_w_rstn;
    logic                r_hw_drop;

    assign w_hw_write = (bus.hw_op_i == CSR_OP_WRITE);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam bit HAS_HW = (gi == IDX_A_ADDR) || (gi == IDX_W_ADDR);
            logic w_hw_we;
            logic w_hw_en;

            if (HAS_HW) begin : g_hw
                assign w_hw_we = w_hw_write && (bus.hw_addr_i == reg_addr(gi));
                assign w_hw_en = (gi == IDX_A_ADDR) ? w_q[IDX_CTRL][0] : w_q[IDX_CTRL][1];
            end else begin : g_nohw
                assign w_hw_we = 1'b0;
                assign w_hw_en = 1'b0;
            end

            macload_csr_reg #(
                .DATA_W    (DATA_W),
                .RESET_VAL ((gi == IDX_CTRL) ? CTRL_RESET : {DATA_W{1'b0}}),
                .WR_MASK   ((gi == IDX_CTRL) ? CTRL_MASK  : {DATA_W{1'b1}}),
                .HAS_HW    (HAS_HW)
            ) u_reg (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .sw_op_i      (bus.sw_op_i),
                .sw_sel_i     (bus.sw_addr_i == reg_addr(gi)),
                .sw_wdata_i   (bus.sw_wdata_i),
                .hw_we_i      (w_hw_we),
                .hw_en_i      (w_hw_en),
                .hw_wdata_i   (bus.hw_wdata_i),
                .q_o          (w_q[gi]),
                .sw_wrote_o   (w_sw_wrote[gi]),
                .hw_dropped_o (w_hw_dropped[gi])
            );
        end
    endgenerate

    // Read path shows the pre-write value; no bypass of same-cycle writes.
    always_comb begin
        bus.sw_hit_o   = 1'b0;
        bus.sw_rdata_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.sw_addr_i == reg_addr(i)) begin
                bus.sw_hit_o   = 1'b1;
                bus.sw_rdata_o = w_q[i];
            end
        end
    end

    // Counter resets idle low during reset so the controller starts cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a_rstn  <= 1'b0;
            r_w_rstn  <= 1'b0;
            r_hw_drop <= 1'b0;
        end else begin
            r_a_rstn  <= ~|(w_sw_wrote & A_GROUP_MASK);
            r_w_rstn  <= ~|(w_sw_wrote & W_GROUP_MASK);
            r_hw_drop <= |w_hw_dropped;
        end
    end

    assign bus.a_address_o  = w_q[IDX_A_ADDR];
    assign bus.w_address_o  = w_q[IDX_W_ADDR];
    assign bus.a_stride_o   = w_q[IDX_A_STRIDE];
    assign bus.w_stride_o   = w_q[IDX_W_STRIDE];
    assign bus.a_rollback_o = w_q[IDX_A_ROLLBACK];
    assign bus.w_rollback_o = w_q[IDX_W_ROLLBACK];
    assign bus.a_skip_o     = w_q[IDX_A_SKIP];
    assign bus.w_skip_o     = w_q[IDX_W_SKIP];
    assign bus.csr_a_rstn_o = r_a_rstn;
    assign bus.csr_w_rstn_o = r_w_rstn;
    assign bus.hw_drop_o    = r_hw_drop;

endmodule

// File: tb/tb_macload_csr_bank.sv
// Bench for macload_csr_bank: directed vector table, reset corner cases and
// randomized traffic against a behavioural register-bank model.
module tb_macload_csr_bank;
    import macload_csr_bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    macload_csr_bank_if #(.DATA_W(32)) bus ();

    macload_csr_bank #(.DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [1:0] hop, input logic [11:0] haddr, input logic [31:0] hwd);
        bus.sw_op_i    = op;
        bus.sw_addr_i  = addr;
        bus.sw_wdata_i = wd;
        bus.hw_op_i    = hop;
        bus.hw_addr_i  = haddr;
        bus.hw_wdata_i = hwd;
    endtask

    // ---------------- behavioural model ----------------
    // Registers held by address; CTRL bits 0/1 gate hardware writes to A/W address.
    logic [31:0] m_reg [9];
    bit          m_arstn, m_wrstn, m_drop;

    function automatic int addr_idx(input logic [11:0] a);
        for (int i = 0; i < 9; i++) if (a == reg_addr(i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_reg[i] = 32'h0;
        m_reg[8] = 32'h3;
        m_arstn  = 1'b1;
        m_wrstn  = 1'b1;
        m_drop   = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                              input logic [1:0] hop, input logic [11:0] haddr, input logic [31:0] hwd);
        logic [31:0] nxt [9];
        int s;
        int t;
        bit sw_act;
        s      = addr_idx(addr);
        sw_act = (s >= 0) && (op != CSR_OP_NONE);
        for (int i = 0; i < 9; i++) nxt[i] = m_reg[i];
        m_drop = 1'b0;
        if (hop == CSR_OP_WRITE && (haddr == CSR_A_ADDR || haddr == CSR_W_ADDR)) begin
            t = (haddr == CSR_A_ADDR) ? 0 : 1;
            if (m_reg[8][t] == 1'b0 || (sw_act && s == t)) m_drop = 1'b1;
            else nxt[t] = hwd;
        end
        if (sw_act) begin
            case (op)
                CSR_OP_WRITE: nxt[s] = wd;
                CSR_OP_SET:   nxt[s] = m_reg[s] | wd;
                default:      nxt[s] = m_reg[s] & ~wd;
            endcase
            if (s == 8) nxt[s] = nxt[s] & 32'h3;
        end
        m_arstn = !(sw_act && (s == 0 || s == 2 || s == 4 || s == 6));
        m_wrstn = !(sw_act && (s == 1 || s == 3 || s == 5 || s == 7));
        for (int i = 0; i < 9; i++) m_reg[i] = nxt[i];
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".a_addr"},  bus.a_address_o,  m_reg[0]);
        chk({tag, ".w_addr"},  bus.w_address_o,  m_reg[1]);
        chk({tag, ".a_stride"}, bus.a_stride_o,  m_reg[2]);
        chk({tag, ".w_stride"}, bus.w_stride_o,  m_reg[3]);
        chk({tag, ".a_rb"},    bus.a_rollback_o, m_reg[4]);
        chk({tag, ".w_rb"},    bus.w_rollback_o, m_reg[5]);
        chk({tag, ".a_skip"},  bus.a_skip_o,     m_reg[6]);
        chk({tag, ".w_skip"},  bus.w_skip_o,     m_reg[7]);
        chk({tag, ".a_rstn"},  32'(bus.csr_a_rstn_o), 32'(m_arstn));
        chk({tag, ".w_rstn"},  32'(bus.csr_w_rstn_o), 32'(m_wrstn));
        chk({tag, ".drop"},    32'(bus.hw_drop_o),    32'(m_drop));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [1:0]  hop;
        logic [11:0] haddr;
        logic [31:0] hwd;
        bit          e_hit;
        logic [31:0] e_rd;
        logic [31:0] e_a;
        logic [31:0] e_w;
        logic [31:0] e_ws;
        bit          e_arstn;
        bit          e_wrstn;
        bit          e_drop;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [1:0]  r_op, r_hop;
        logic [11:0] r_addr, r_haddr;
        logic [31:0] r_wd, r_hwd;
        logic        exp_hit;
        logic [31:0] exp_rd;
        int          idx;

        tbl[0]  = '{CSR_OP_WRITE, CSR_A_ADDR,       32'h1000,      CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h0,    32'h1000, 32'h0,    32'h0, 0, 1, 0};
        tbl[1]  = '{CSR_OP_SET,   CSR_A_ADDR,       32'h0F,        CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h1000, 32'h100F, 32'h0,    32'h0, 0, 1, 0};
        tbl[2]  = '{CSR_OP_CLEAR, CSR_A_ADDR,       32'h03,        CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h100F, 32'h100C, 32'h0,    32'h0, 0, 1, 0};
        tbl[3]  = '{CSR_OP_NONE,  CSR_A_ADDR,       32'h0,         CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h100C, 32'h100C, 32'h0,    32'h0, 1, 1, 0};
        tbl[4]  = '{CSR_OP_NONE,  CSR_MACLOAD_CTRL, 32'h0,         CSR_OP_WRITE, CSR_W_ADDR,   32'h2010, 1, 32'h3,    32'h100C, 32'h2010, 32'h0, 1, 1, 0};
        tbl[5]  = '{CSR_OP_WRITE, CSR_A_ADDR,       32'h40,        CSR_OP_WRITE, CSR_A_ADDR,   32'h99,   1, 32'h100C, 32'h40,   32'h2010, 32'h0, 0, 1, 1};
        tbl[6]  = '{CSR_OP_CLEAR, CSR_MACLOAD_CTRL, 32'h1,         CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h3,    32'h40,   32'h2010, 32'h0, 1, 1, 0};
        tbl[7]  = '{CSR_OP_NONE,  12'hFFF,          32'h0,         CSR_OP_WRITE, CSR_A_ADDR,   32'h55,   0, 32'h0,    32'h40,   32'h2010, 32'h0, 1, 1, 1};
        tbl[8]  = '{CSR_OP_WRITE, CSR_W_STRIDE,     32'h8,         CSR_OP_WRITE, CSR_W_ADDR,   32'h3000, 1, 32'h0,    32'h40,   32'h3000, 32'h8, 1, 0, 0};
        tbl[9]  = '{CSR_OP_NONE,  CSR_W_ADDR,       32'h0,         CSR_OP_SET,   CSR_W_ADDR,   32'h77,   1, 32'h3000, 32'h40,   32'h3000, 32'h8, 1, 1, 0};
        tbl[10] = '{CSR_OP_WRITE, CSR_MACLOAD_CTRL, 32'hFFFF_FFFF, CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h2,    32'h40,   32'h3000, 32'h8, 1, 1, 0};
        tbl[11] = '{CSR_OP_NONE,  CSR_MACLOAD_CTRL, 32'h0,         CSR_OP_NONE,  12'h000,      32'h0,    1, 32'h3,    32'h40,   32'h3000, 32'h8, 1, 1, 0};
        tbl[12] = '{CSR_OP_WRITE, 12'h123,          32'hDEAD,      CSR_OP_WRITE, CSR_A_STRIDE, 32'h1234, 0, 32'h0,    32'h40,   32'h3000, 32'h8, 1, 1, 0};
        tbl[13] = '{CSR_OP_SET,   CSR_W_ADDR,       32'h1,         CSR_OP_WRITE, CSR_W_ADDR,   32'h5,    1, 32'h3000, 32'h40,   32'h3001, 32'h8, 1, 0, 1};

        // ---- reset ----
        drive(CSR_OP_NONE, CSR_MACLOAD_CTRL, 32'h0, CSR_OP_NONE, 12'h000, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        m_arstn = 1'b0;
        m_wrstn = 1'b0;
        check_model("reset");
        chk("reset.ctrl_rd",  bus.sw_rdata_o, 32'h3);
        chk("reset.ctrl_hit", 32'(bus.sw_hit_o), 32'h1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_model("release");
        $display("reset: rstn a=%0b w=%0b after release", bus.csr_a_rstn_o, bus.csr_w_rstn_o);

        // ---- directed table ----
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].hop, tbl[i].haddr, tbl[i].hwd);
            #1;
            chk($sformatf("vec%0d.hit", i), 32'(bus.sw_hit_o), 32'(tbl[i].e_hit));
            chk($sformatf("vec%0d.rd", i),  bus.sw_rdata_o,    tbl[i].e_rd);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.a_addr", i),   bus.a_address_o, tbl[i].e_a);
            chk($sformatf("vec%0d.w_addr", i),   bus.w_address_o, tbl[i].e_w);
            chk($sformatf("vec%0d.w_stride", i), bus.w_stride_o,  tbl[i].e_ws);
            chk($sformatf("vec%0d.a_rstn", i), 32'(bus.csr_a_rstn_o), 32'(tbl[i].e_arstn));
            chk($sformatf("vec%0d.w_rstn", i), 32'(bus.csr_w_rstn_o), 32'(tbl[i].e_wrstn));
            chk($sformatf("vec%0d.drop", i),   32'(bus.hw_drop_o),    32'(tbl[i].e_drop));
            $display("vec %0d: op=%0d addr=%03h hop=%0d haddr=%03h a=%08h w=%08h drop=%0b",
                     i, tbl[i].op, tbl[i].addr, tbl[i].hop, tbl[i].haddr,
                     bus.a_address_o, bus.w_address_o, bus.hw_drop_o);
        end
        chk("vec.a_stride_untouched", bus.a_stride_o, 32'h0);

        // ---- reset raised before the edge that would launch strobes ----
        drive(CSR_OP_WRITE, CSR_A_ADDR, 32'h77, CSR_OP_WRITE, CSR_A_ADDR, 32'h99);
        #2 rst = 1'b1;
        #1;
        chk("rstA.async_a_addr", bus.a_address_o, 32'h0);
        chk("rstA.async_w_addr", bus.w_address_o, 32'h0);
        @(posedge clk);
        #1;
        chk("rstA.drop", 32'(bus.hw_drop_o),    32'h0);
        chk("rstA.a_rstn_low", 32'(bus.csr_a_rstn_o), 32'h0);
        chk("rstA.a_addr", bus.a_address_o, 32'h0);
        drive(CSR_OP_NONE, 12'h000, 32'h0, CSR_OP_NONE, 12'h000, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        $display("midreset A: drop=%0b a=%08h", bus.hw_drop_o, bus.a_address_o);

        // ---- reset raised while strobes are asserted ----
        drive(CSR_OP_WRITE, CSR_A_ADDR, 32'h77, CSR_OP_WRITE, CSR_A_ADDR, 32'h99);
        @(posedge clk);
        #1;
        chk("rstB.pre_drop",   32'(bus.hw_drop_o), 32'h1);
        chk("rstB.pre_a_addr", bus.a_address_o,    32'h77);
        drive(CSR_OP_NONE, CSR_MACLOAD_CTRL, 32'h0, CSR_OP_NONE, 12'h000, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rstB.drop_cut", 32'(bus.hw_drop_o), 32'h0);
        chk("rstB.a_addr",   bus.a_address_o,    32'h0);
        chk("rstB.ctrl_rd",  bus.sw_rdata_o,     32'h3);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_model("rstB.release");
        $display("midreset B: drop=%0b a=%08h", bus.hw_drop_o, bus.a_address_o);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            r_op    = 2'($urandom_range(0, 3));
            r_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : reg_addr(int'($urandom_range(0, 8)));
            r_wd    = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 15));
            r_hop   = 2'($urandom_range(0, 3));
            r_haddr = ($urandom_range(0, 5) == 0) ? reg_addr(int'($urandom_range(2, 8)))
                    : (($urandom_range(0, 1) == 1) ? CSR_A_ADDR : CSR_W_ADDR);
            r_hwd   = 32'($urandom);
            drive(r_op, r_addr, r_wd, r_hop, r_haddr, r_hwd);
            idx     = addr_idx(r_addr);
            exp_hit = (idx >= 0);
            exp_rd  = (idx >= 0) ? m_reg[idx] : 32'h0;
            #1;
            chk($sformatf("rnd%0d.hit", n), 32'(bus.sw_hit_o), 32'(exp_hit));
            chk($sformatf("rnd%0d.rd", n),  bus.sw_rdata_o,    exp_rd);
            @(posedge clk);
            #1;
            model_step(r_op, r_addr, r_wd, r_hop, r_haddr, r_hwd);
            check_model($sformatf("rnd%0d", n));
            $display("rnd %0d: op=%0d addr=%03h hop=%0d haddr=%03h a=%08h w=%08h ar=%0b wr=%0b drop=%0b",
                     n, r_op, r_addr, r_hop, r_haddr, bus.a_address_o, bus.w_address_o,
                     bus.csr_a_rstn_o, bus.csr_w_rstn_o, bus.hw_drop_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/macload_csr_bank.md
# macload_csr_bank

Register bank holding the MAC-load address-generation state: activation/weight address, stride, rollback and skip registers, plus a control register. Sits between the CSR instruction path (software accesses) and the MAC-load address controller: it feeds that controller its address, stride, rollback, skip and counter-reset inputs, and it consumes the controller's hardware write-back of the updated address. It arbitrates software and hardware writes. It generates the counter-reset strobes that resynchronise the controller's update counters after software reprogramming.

## Interface
Parameters:
- DATA_W, 32, register width; only 32 is supported.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- sw_op_i  in  2  software CSR op: CSR_OP_NONE/WRITE/SET/CLEAR
- sw_addr_i  in  12  software CSR address
- sw_wdata_i  in  32  software write/set/clear operand
- sw_hit_o  out  1  sw_addr_i decodes to a bank register (combinational)
- sw_rdata_o  out  32  read data of addressed register, 0 on miss (combinational)
- hw_op_i  in  2  hardware op from address controller
- hw_addr_i  in  12  hardware target, CSR_A_ADDR or CSR_W_ADDR
- hw_wdata_i  in  32  updated address from address controller
- a_address_o, w_address_o  out  32 each  current address registers
- a_stride_o, w_stride_o, a_rollback_o, w_rollback_o, a_skip_o, w_skip_o  out  32 each  current configuration registers
- csr_a_rstn_o, csr_w_rstn_o  out  1 each  active-low counter resets to controller
- hw_drop_o  out  1  one-cycle pulse: a hardware write was discarded

## Operation
- Registers: A_ADDR, W_ADDR, A_STRIDE, W_STRIDE, A_ROLLBACK, W_ROLLBACK, A_SKIP, W_SKIP, CTRL.
  - CTRL bit0 = a_hw_en, bit1 = w_hw_en; bits 31:2 read 0 and ignore writes.
- Software ops:
  - WRITE: reg <= wdata.
  - SET: reg <= reg | wdata.
  - CLEAR: reg <= reg & ~wdata.
  - NONE: read only.
  - Unmapped address: no effect, sw_hit_o=0, sw_rdata_o=0.
- Hardware ops:
  - Only hw_op_i==CSR_OP_WRITE with hw_addr_i==CSR_A_ADDR or CSR_W_ADDR is honoured.
  - Other op codes and addresses are ignored silently, with no drop pulse.
- A hardware write to A_ADDR is discarded, with hw_drop_o=1 next cycle, when:
  - CTRL.a_hw_en=0, or
  - a software op other than NONE targets A_ADDR in the same cycle; software wins.
- Same rule for W_ADDR with w_hw_en.
- A simultaneous software write to a different register and a hardware write both take effect.
- Any software SET/CLEAR/WRITE to an A-group register (A_ADDR, A_STRIDE, A_ROLLBACK, A_SKIP) drives csr_a_rstn_o low for exactly the following cycle. Same for the W-group and csr_w_rstn_o.
- Hardware writes never assert the counter resets.
- Writes to CTRL assert neither counter reset.
- Arithmetic is bitwise only; no wrap logic, values stored verbatim.

## Timing
- Reset values:
  - All data registers 0; CTRL = 0x3.
  - csr_a_rstn_o = csr_w_rstn_o = 0 while rst_i is high and 1 after release.
  - hw_drop_o = 0.
- Register outputs update one cycle after the write edge.
- sw_rdata_o reflects the pre-write value in the write cycle (no bypass).
- Counter-reset and drop strobes are registered: asserted in cycle N+1 for an event in cycle N, one cycle wide. Back-to-back triggering writes hold the strobe low continuously.
- rst_i mid-operation aborts all pending strobes and restores reset values immediately (asynchronous).

## Structure
- New CSR address constants CSR_A_STRIDE, CSR_W_STRIDE, CSR_A_ROLLBACK, CSR_W_ROLLBACK, CSR_A_SKIP, CSR_W_SKIP and CSR_MACLOAD_CTRL go in riscv_defines, next to the existing CSR_A_ADDR, CSR_W_ADDR and CSR_OP_* constants.
- Sub-module macload_csr_reg: one 32-bit register with software op decode, optional hardware write port, enable and priority. It outputs "sw_wrote" and "hw_dropped" flags. It is instantiated 9 times, with the hardware port tied off except for A_ADDR and W_ADDR.

## Test plan
- Reset:
  - Stimulus: assert rst_i, release.
  - Required: all outputs 0; sw_rdata_o at CSR_MACLOAD_CTRL = 0x3; rstn outputs 0 during reset and 1 one cycle after release.
- Software write and read:
  - Stimulus: WRITE 0x1000 to CSR_A_ADDR.
  - Required next cycle: a_address_o=0x1000 and csr_a_rstn_o=0 for one cycle.
  - Follow-up: SET 0x0F then CLEAR 0x03 gives 0x100C; csr_w_rstn_o stays 1 throughout.
- Hardware update:
  - Stimulus: hw WRITE 0x2010 to CSR_W_ADDR.
  - Required: w_address_o=0x2010 next cycle, no counter reset, hw_drop_o=0.
- Collision:
  - Stimulus: same cycle, software WRITE 0x40 and hardware WRITE 0x99 to CSR_A_ADDR.
  - Required: a_address_o=0x40, hw_drop_o=1 for one cycle, csr_a_rstn_o=0 for one cycle.
- Enable gating and parallel writes:
  - Stimulus: CLEAR 0x1 on CTRL, then hw WRITE to CSR_A_ADDR.
  - Required: value unchanged and hw_drop_o pulses.
  - Stimulus: concurrent software WRITE 0x8 to CSR_W_STRIDE and hw WRITE to CSR_W_ADDR.
  - Required: both registers update.
- Mid-operation reset:
  - Stimulus: raise rst_i in the cycle a strobe is due.
  - Required: strobe suppressed and all registers return to reset values asynchronously.
